divider_core_seq: RTL



---
 rtl/divider_core_seq_pkg.sv | 16 +
 rtl/divider_step.sv | 28 ++
 rtl/divider_core_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/divider_core_seq_pkg.sv
// rtl/divider_core_seq_pkg.sv - shared types for the sequential restoring divider
package divider_core_seq_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

   typedef logic [DIV_WIDTH-1:0]   word_t;
   typedef logic [2*DIV_WIDTH-1:0] dword_t;

   typedef enum logic [1:0] {
      DIV_IDLE,
      DIV_BUSY,
      DIV_DONE
   } div_state_t;

endpackage

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one unsigned restoring-division iteration
module divider_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH:0]   rem_next,
   output logic [WIDTH-1:0] q_next
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   // rem never reaches 2*divisor, so dropping its msb on the shift loses nothing
   always_comb begin
      shifted = (rem << 1) | {{WIDTH{1'b0}}, q[WIDTH-1]};
      trial   = shifted - {1'b0, divisor};
      if (!trial[WIDTH]) begin
         rem_next = trial;
         q_next   = {q[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = shifted;
         q_next   = {q[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/divider_core_seq.sv
// rtl/divider_core_seq.sv - multi-cycle unsigned radix-2 divider, {remainder, quotient} out
module divider_core_seq
   import divider_core_seq_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               valid,
   input  logic               flush,
   input  logic [WIDTH-1:0]   a_in,
   input  logic [WIDTH-1:0]   b_in,
   output logic               ready,
   output logic               done,
   output logic [2*WIDTH-1:0] out
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   div_q, div_d;
   logic [2*WIDTH-1:0] out_q, out_d;
   logic               done_q, done_d;
   logic               ready_q, ready_d;

   logic [WIDTH:0]     step_rem;
   logic [WIDTH-1:0]   step_quo;

   divider_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .q        (quo_q),
      .divisor  (div_q),
      .rem_next (step_rem),
      .q_next   (step_quo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      out_d   = out_q;
      done_d  = 1'b0;
      unique case (state_q)
         DIV_IDLE: begin
            if (valid) begin
               state_d = DIV_BUSY;
               div_d   = a_in;
               quo_d   = b_in;
               rem_d   = '0;
               cnt_d   = '0;
            end
         end
         DIV_BUSY: begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               state_d = DIV_DONE;
               done_d  = 1'b1;
               out_d   = {step_rem[WIDTH-1:0], step_quo};
            end
         end
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
      // flush wins over accept and over completion; the result bus keeps its old value
      if (flush) begin
         state_d = DIV_IDLE;
         done_d  = 1'b0;
         out_d   = out_q;
      end
      ready_d = (state_d == DIV_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         out_q   <= out_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign out   = out_q;

endmodule
